// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared state encodings and constants for the pipeline controller
package pipe_ctrl_pkg;
  typedef enum logic [1:0] {
    PC_RUN     = 2'd0,
    PC_MD_WAIT = 2'd1,
    PC_FLUSH   = 2'd2
  } pc_state_e;
  localparam logic [4:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/pipe_ctrl_hazard_cmp.sv
// hazard_cmp: load-use comparator, flags an ID source matching the rd of a load in EX
module hazard_cmp
  import pipe_ctrl_pkg::*;
(
  input  logic       mem_read_i,
  input  logic [4:0] waddr_i,
  input  logic       re1_i,
  input  logic [4:0] raddr1_i,
  input  logic       re2_i,
  input  logic [4:0] raddr2_i,
  output logic       hazard_o
);
  assign hazard_o = mem_read_i && waddr_i != REG_ZERO &&
                    ((re1_i && raddr1_i == waddr_i) || (re2_i && raddr2_i == waddr_i));
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: hazard/flush controller for the five-stage core; PIPE_CTRL_PERF_EN adds stall/flush counters
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYC = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_reg1_RE_i,
  input  logic       id_reg2_RE_i,
  input  logic [4:0] id_reg1_raddr_i,
  input  logic [4:0] id_reg2_raddr_i,
  input  logic       id_jump_en_i,
  input  logic       idex_mem_read_i,
  input  logic [4:0] idex_reg_waddr_i,
  input  logic       ex_ins_flush_i,
  input  logic       ex_md_req_i,
  input  logic       md_done_i,
  output logic       md_start_o,
  output logic       pc_hold_o,
  output logic       ifid_hold_o,
  output logic       ifid_flush_o,
  output logic       idex_hold_o,
  output logic       idex_flush_o,
  output logic       exmem_flush_o,
  output logic       jump_valid_o
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o
`endif
);
  localparam logic [1:0] FC = 2'(FLUSH_CYC);
  pc_state_e state_q, state_d;
  logic [1:0] fcnt_q, fcnt_d;
  logic hazard;
  hazard_cmp u_hazard_cmp (
    .mem_read_i (idex_mem_read_i),
    .waddr_i    (idex_reg_waddr_i),
    .re1_i      (id_reg1_RE_i),
    .raddr1_i   (id_reg1_raddr_i),
    .re2_i      (id_reg2_RE_i),
    .raddr2_i   (id_reg2_raddr_i),
    .hazard_o   (hazard)
  );
  // state and kill-cycle counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= PC_RUN;
      fcnt_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end
  // event priority: mul/div wait, branch redirect, kill window, mul/div start, load-use, jump
  always_comb begin
    state_d       = state_q;
    fcnt_d        = fcnt_q;
    md_start_o    = 1'b0;
    pc_hold_o     = 1'b0;
    ifid_hold_o   = 1'b0;
    ifid_flush_o  = 1'b0;
    idex_hold_o   = 1'b0;
    idex_flush_o  = 1'b0;
    exmem_flush_o = 1'b0;
    jump_valid_o  = 1'b0;
    if (state_q == PC_MD_WAIT) begin
      if (md_done_i) state_d = PC_RUN;
      pc_hold_o     = !md_done_i;
      ifid_hold_o   = !md_done_i;
      idex_hold_o   = !md_done_i;
      exmem_flush_o = !md_done_i;
    end else if (ex_ins_flush_i) begin
      ifid_flush_o = 1'b1;
      idex_flush_o = 1'b1;
      state_d      = PC_FLUSH;
      fcnt_d       = FC;
    end else if (state_q == PC_FLUSH) begin
      ifid_flush_o = 1'b1;
      fcnt_d       = fcnt_q - 2'd1;
      state_d      = fcnt_q == 2'd1 ? PC_RUN : PC_FLUSH;
    end else if (ex_md_req_i && !md_done_i) begin
      md_start_o    = 1'b1;
      pc_hold_o     = 1'b1;
      ifid_hold_o   = 1'b1;
      idex_hold_o   = 1'b1;
      exmem_flush_o = 1'b1;
      state_d       = PC_MD_WAIT;
    end else if (hazard) begin
      pc_hold_o    = 1'b1;
      ifid_hold_o  = 1'b1;
      idex_flush_o = 1'b1;
    end else if (id_jump_en_i) begin
      jump_valid_o = 1'b1;
      state_d      = PC_FLUSH;
      fcnt_d       = FC;
    end
  end
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;
  // saturating counts of stalled and killed cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      if (pc_hold_o && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (ifid_flush_o && flush_cnt_q != '1) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end
  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: scoreboard bench for pipe_ctrl with FLUSH_CYC=2
module tb_pipe_ctrl;
  localparam int FC = 2;
  localparam logic [7:0] NONE  = 8'b0000_0000;
  localparam logic [7:0] START = 8'b1000_0000;
  localparam logic [7:0] HOLDS = 8'b0110_1010;
  localparam logic [7:0] LU    = 8'b0110_0100;
  localparam logic [7:0] BR    = 8'b0001_0100;
  localparam logic [7:0] KILL  = 8'b0001_0000;
  localparam logic [7:0] JV    = 8'b0000_0001;
  logic clk = 1'b0;
  logic rst;
  logic re1, re2, jump, mrd, exf, mdreq, mddone;
  logic [4:0] ra1, ra2, wa;
  logic md_start, pc_hold, ifid_hold, ifid_flush, idex_hold, idex_flush, exmem_flush, jump_valid;
  logic [7:0] outs;
  logic [7:0] exp_q[$];
  int n_tests = 0;
  int n_fail = 0;
  int m_stall = 0;
  int m_flush = 0;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif
  assign outs = {md_start, pc_hold, ifid_hold, ifid_flush, idex_hold, idex_flush, exmem_flush, jump_valid};
  always #5 clk = ~clk;
  pipe_ctrl #(.FLUSH_CYC(FC)) dut (
    .clk              (clk),
    .rst              (rst),
    .id_reg1_RE_i     (re1),
    .id_reg2_RE_i     (re2),
    .id_reg1_raddr_i  (ra1),
    .id_reg2_raddr_i  (ra2),
    .id_jump_en_i     (jump),
    .idex_mem_read_i  (mrd),
    .idex_reg_waddr_i (wa),
    .ex_ins_flush_i   (exf),
    .ex_md_req_i      (mdreq),
    .md_done_i        (mddone),
    .md_start_o       (md_start),
    .pc_hold_o        (pc_hold),
    .ifid_hold_o      (ifid_hold),
    .ifid_flush_o     (ifid_flush),
    .idex_hold_o      (idex_hold),
    .idex_flush_o     (idex_flush),
    .exmem_flush_o    (exmem_flush),
    .jump_valid_o     (jump_valid)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .stall_cnt_o      (stall_cnt),
    .flush_cnt_o      (flush_cnt)
`endif
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic idle();
    {re1, re2, jump, mrd, exf, mdreq, mddone} = '0;
    ra1 = '0;
    ra2 = '0;
    wa  = '0;
  endtask
  task automatic step(input string tag, input logic [7:0] exp);
    exp_q.push_back(exp);
    @(negedge clk);
    chk(tag, 32'(outs), 32'(exp_q.pop_front()));
    @(posedge clk);
    if (rst) begin
      m_stall = 0;
      m_flush = 0;
    end else begin
      m_stall += int'(exp[6]);
      m_flush += int'(exp[4]);
    end
    #1;
  endtask
  task automatic chk_perf(input string tag);
`ifdef PIPE_CTRL_PERF_EN
    chk({tag, "_stall"}, stall_cnt, 32'(m_stall));
    chk({tag, "_flush"}, flush_cnt, 32'(m_flush));
`else
    if (tag.len() == 0) $display("perf counters not built");
`endif
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
  end
  initial begin
    rst = 1'b1;
    idle();
    step("rst", NONE);
    rst = 1'b0;
    step("post_rst", NONE);
    chk_perf("reset");
    mrd = 1'b1; wa = 5'd5; re1 = 1'b1; ra1 = 5'd5; jump = 1'b1;
    step("lu_rs1", LU);
    mrd = 1'b0;
    step("lu_reeval_jump", JV);
    jump = 1'b0;
    for (int i = 0; i < FC; i++) step("jump_kill", KILL);
    step("jump_done", NONE);
    idle();
    mrd = 1'b1; wa = 5'd0; re1 = 1'b1; ra1 = 5'd0;
    step("lu_x0", NONE);
    idle();
    mrd = 1'b1; wa = 5'd7; re2 = 1'b1; ra2 = 5'd7; ra1 = 5'd3; re1 = 1'b1;
    step("lu_rs2", LU);
    re2 = 1'b0;
    step("lu_rs2_clear", NONE);
    idle();
    jump = 1'b1;
    step("jump", JV);
    mrd = 1'b1; wa = 5'd9; re1 = 1'b1; ra1 = 5'd9;
    for (int i = 0; i < FC; i++) step("jump_kill_ign", KILL);
    idle();
    step("jump_end", NONE);
    exf = 1'b1; jump = 1'b1;
    step("br_vs_jump", BR);
    idle();
    for (int i = 0; i < FC; i++) step("br_kill", KILL);
    step("br_end", NONE);
    chk_perf("mid");
    exf = 1'b1;
    step("br1", BR);
    exf = 1'b0;
    step("br1_kill", KILL);
    exf = 1'b1;
    step("br2_reload", BR);
    exf = 1'b0;
    for (int i = 0; i < FC; i++) step("br2_kill", KILL);
    step("br2_end", NONE);
    mdreq = 1'b1;
    step("md_c0", START | HOLDS);
    exf = 1'b1; jump = 1'b1;
    step("md_c1_ign", HOLDS);
    exf = 1'b0; jump = 1'b0;
    step("md_c2", HOLDS);
    mddone = 1'b1;
    step("md_c3_done", NONE);
    idle();
    step("md_after", NONE);
    mdreq = 1'b1; mddone = 1'b1;
    step("md_single", NONE);
    idle();
    step("md_single_after", NONE);
    chk_perf("pre_rst");
    mdreq = 1'b1;
    step("md_rst_c0", START | HOLDS);
    mdreq = 1'b0; rst = 1'b1;
    step("md_rst_c1", HOLDS);
    rst = 1'b0;
    step("md_rst_after", NONE);
    chk_perf("md_rst");
    mrd = 1'b1; wa = 5'd4; re1 = 1'b1; ra1 = 5'd4;
    step("run_after_rst", LU);
    idle();
    exf = 1'b1;
    step("fl_rst_br", BR);
    exf = 1'b0; rst = 1'b1;
    step("fl_rst_kill", KILL);
    rst = 1'b0;
    step("fl_rst_after", NONE);
    chk_perf("fl_rst");
    jump = 1'b1;
    step("fl_rst_jump", JV);
    idle();
    for (int i = 0; i < FC; i++) step("fl_rst_jkill", KILL);
    step("final", NONE);
    chk_perf("final");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
